// File: rtl/io_timer_periph.sv
// I/O slot responder with a 4-register down-counting timer (CTRL, LOAD, COUNT, STATUS).
// Bus accesses pass through IDLE -> WAIT -> RESP -> HOLD; io_ready pulses for the RESP cycle.
module io_timer_periph #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  inout  wire  [DATA_WIDTH-1:0] io_data,
  input  logic                  io_read,
  input  logic                  io_write,
  output logic                  io_ready,
  output logic                  irq
);

  typedef enum logic [1:0] {StIdle, StWait, StResp, StHold} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LOAD   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(3);
  localparam logic [3:0]            WAIT_INIT   = 4'(WAIT_STATES);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_wait_cnt;
  logic [3:0]              w_wait_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_op_read;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [2:0]              r_ctrl;
  logic [DATA_WIDTH-1:0]   r_load;
  logic [DATA_WIDTH-1:0]   r_count;
  logic                    r_expired;

  logic                    w_latch;
  logic                    w_snap;
  logic                    w_commit;
  logic                    w_drive;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic [DATA_WIDTH-1:0]   w_rd_val;
  logic                    w_wr_ctrl;
  logic                    w_wr_load;
  logic                    w_wr_status;
  logic                    w_fire;
  logic                    w_dec;

  // Bus FSM: next state and strobes
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_latch     = 1'b0;
    w_snap      = 1'b0;
    w_commit    = 1'b0;
    io_ready    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_read || io_write) begin
          w_latch    = 1'b1;
          w_wait_nxt = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            w_state_nxt = StResp;
            w_snap      = 1'b1;
          end else begin
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        w_wait_nxt = r_wait_cnt - 4'd1;
        if (r_wait_cnt == 4'd1) begin
          w_state_nxt = StResp;
          w_snap      = 1'b1;
        end
      end
      StResp: begin
        io_ready    = 1'b1;
        w_commit    = !r_op_read;
        w_state_nxt = StHold;
      end
      StHold: begin
        if (!io_read && !io_write) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // With zero wait states the snapshot is taken on the sampling edge, before r_addr is loaded
  assign w_rd_addr = (r_state == StIdle) ? io_addr : r_addr;

  always_comb begin
    w_rd_val = '0;
    unique case (w_rd_addr)
      ADDR_CTRL:   w_rd_val = {{(DATA_WIDTH-3){1'b0}}, r_ctrl};
      ADDR_LOAD:   w_rd_val = r_load;
      ADDR_COUNT:  w_rd_val = r_count;
      ADDR_STATUS: w_rd_val = {{(DATA_WIDTH-1){1'b0}}, r_expired};
      default:     w_rd_val = '0;
    endcase
  end

  assign w_drive     = ((r_state == StResp) || (r_state == StHold)) && io_read && r_op_read;
  assign io_data     = w_drive ? r_rdata : {DATA_WIDTH{1'bz}};

  assign w_wr_ctrl   = w_commit && (r_addr == ADDR_CTRL);
  assign w_wr_load   = w_commit && (r_addr == ADDR_LOAD);
  assign w_wr_status = w_commit && (r_addr == ADDR_STATUS) && io_data[0];
  assign w_fire      = r_ctrl[0] && (r_count == DATA_WIDTH'(1));
  assign w_dec       = r_ctrl[0] && (r_count > DATA_WIDTH'(1));

  assign irq = r_expired & r_ctrl[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
      r_op_read  <= 1'b0;
      r_rdata    <= '0;
      r_ctrl     <= 3'b000;
      r_load     <= '0;
      r_count    <= '0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_latch) begin
        r_addr    <= io_addr;
        r_op_read <= io_read;
      end
      if (w_snap) r_rdata <= w_rd_val;
      if (w_wr_ctrl) r_ctrl <= io_data[2:0];
      // A LOAD write overrides whatever the timer would do to COUNT on this edge
      if (w_wr_load) begin
        r_load  <= io_data;
        r_count <= io_data;
      end else if (w_fire) begin
        r_count <= r_ctrl[1] ? r_load : '0;
      end else if (w_dec) begin
        r_count <= r_count - DATA_WIDTH'(1);
      end
      if (w_fire) r_expired <= 1'b1;
      else if (w_wr_status) r_expired <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_timer_periph.sv
// Self-checking bench for io_timer_periph: directed scenarios plus randomized bus traffic,
// checked every cycle against a register-level behavioural model of the timer.
module tb_io_timer_periph;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int WS = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] io_addr;
  wire  [DW-1:0] io_data;
  logic          io_read;
  logic          io_write;
  logic          io_ready;
  logic          irq;

  // Bench drives io_data whenever the DUT must not, so a stray DUT driver corrupts the probe
  logic          tb_en;
  logic [DW-1:0] tb_val;
  assign io_data = tb_en ? tb_val : {DW{1'bz}};

  always #5 clk = ~clk;

  io_timer_periph #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_data  (io_data),
    .io_read  (io_read),
    .io_write (io_write),
    .io_ready (io_ready),
    .irq      (irq)
  );

  // Architectural model
  logic [2:0]    m_ctrl;
  logic [DW-1:0] m_load;
  logic [DW-1:0] m_count;
  logic          m_exp;

  logic          exp_ready;
  logic          exp_drive;
  logic [DW-1:0] exp_rdata;
  bit            run_chk;
  int            n_checks;
  int            n_err;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    case (a)
      2'd0:    return {29'b0, m_ctrl};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {31'b0, m_exp};
    endcase
  endfunction

  // One clock edge of the timer, given whether a write is committed on it
  task automatic model_edge(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] n_count;
    logic          n_exp;
    bit            fire;
    if (rst) begin
      m_ctrl = 3'b0; m_load = '0; m_count = '0; m_exp = 1'b0;
      return;
    end
    n_count = m_count;
    n_exp   = m_exp;
    fire    = 1'b0;
    if (m_ctrl[0] && m_count != 0) begin
      if (m_count == 1) begin
        fire    = 1'b1;
        n_count = m_ctrl[1] ? m_load : '0;
      end else begin
        n_count = m_count - 1;
      end
    end
    if (wr) begin
      case (a)
        2'd0: m_ctrl = d[2:0];
        2'd1: begin m_load = d; n_count = d; end
        2'd3: if (d[0]) n_exp = 1'b0;
        default: ;
      endcase
    end
    if (fire) n_exp = 1'b1;
    m_count = n_count;
    m_exp   = n_exp;
  endtask

  task automatic tick(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tb_val = $urandom;
      tick(1'b0, '0, '0);
    end
  endtask

  // Full bus access; hold = extra cycles the strobe stays high after io_ready
  task automatic access(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int hold, output logic [DW-1:0] rdata);
    logic [DW-1:0] snap;
    snap     = '0;
    io_addr  = a;
    io_read  = rd;
    io_write = wr;
    tb_en    = 1'b1;
    tb_val   = d;
    for (int i = 0; i <= WS; i++) begin
      if (i == WS) snap = m_read(a);
      tick(1'b0, '0, '0);
      io_addr = AW'($urandom);
    end
    exp_ready = 1'b1;
    if (rd) begin
      exp_drive = 1'b1;
      exp_rdata = snap;
      tb_en     = 1'b0;
    end
    #1;
    rdata = io_data;
    tick(wr && !rd, a, d);
    exp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (!rd) tb_val = $urandom;
      tick(1'b0, '0, '0);
    end
    io_read   = 1'b0;
    io_write  = 1'b0;
    exp_drive = 1'b0;
    tb_en     = 1'b1;
    tb_val    = $urandom;
    tick(1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      check("io_ready", {31'b0, io_ready}, {31'b0, exp_ready});
      check("irq", {31'b0, irq}, {31'b0, m_exp & m_ctrl[2]});
      if (exp_drive) check("io_data_read", io_data, exp_rdata);
      else           check("io_data_undriven", io_data, tb_val);
    end
  end

  initial begin
    logic [DW-1:0] rd;
    int            op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    n_checks = 0; n_err = 0; run_chk = 1'b0;
    rst = 1'b1; io_read = 1'b0; io_write = 1'b0; io_addr = '0;
    tb_en = 1'b1; tb_val = '0;
    m_ctrl = 3'b0; m_load = '0; m_count = '0; m_exp = 1'b0;
    exp_ready = 1'b0; exp_drive = 1'b0; exp_rdata = '0;

    tick(1'b0, '0, '0);
    run_chk = 1'b1;
    tick(1'b0, '0, '0);
    rst = 1'b0;
    idle(2);

    // Reset values
    access(1'b1, 1'b0, 2'd2, 32'h0, 0, rd);  check("reset_count", rd, 32'h0);
    access(1'b1, 1'b0, 2'd0, 32'h0, 0, rd);  check("reset_ctrl", rd, 32'h0);
    access(1'b1, 1'b0, 2'd3, 32'h0, 0, rd);  check("reset_status", rd, 32'h0);

    // One-shot count from 5 with irq enabled
    access(1'b0, 1'b1, 2'd1, 32'd5, 0, rd);
    access(1'b0, 1'b1, 2'd0, 32'h5, 0, rd);
    access(1'b1, 1'b0, 2'd2, 32'h0, 0, rd);
    idle(10);
    check("oneshot_irq", {31'b0, irq}, 32'd1);
    access(1'b1, 1'b0, 2'd3, 32'h0, 0, rd);  check("oneshot_status", rd, 32'd1);
    access(1'b1, 1'b0, 2'd2, 32'h0, 0, rd);  check("oneshot_count", rd, 32'd0);

    // Auto-reload with period 3; W1C coinciding with an expiry keeps EXPIRED set
    access(1'b0, 1'b1, 2'd0, 32'h0, 0, rd);
    access(1'b0, 1'b1, 2'd3, 32'h1, 0, rd);
    access(1'b1, 1'b0, 2'd3, 32'h0, 0, rd);  check("w1c_clear", rd, 32'd0);
    access(1'b0, 1'b1, 2'd1, 32'd3, 0, rd);
    access(1'b0, 1'b1, 2'd0, 32'h3, 0, rd);
    access(1'b1, 1'b0, 2'd2, 32'h0, 0, rd);  check("auto_count", rd, 32'd1);
    access(1'b1, 1'b0, 2'd3, 32'h0, 0, rd);  check("auto_status", rd, 32'd1);
    access(1'b0, 1'b1, 2'd3, 32'h1, 0, rd);
    access(1'b1, 1'b0, 2'd3, 32'h0, 0, rd);  check("expiry_beats_w1c", rd, 32'd1);
    idle(7);

    // Long-held write commits once; a fresh strobe afterwards completes again
    access(1'b0, 1'b1, 2'd0, 32'h0, 0, rd);
    access(1'b0, 1'b1, 2'd1, 32'h1234, 6, rd);
    access(1'b1, 1'b0, 2'd1, 32'h0, 0, rd);  check("held_write_once", rd, 32'h1234);
    access(1'b0, 1'b1, 2'd1, 32'h77, 0, rd);
    access(1'b1, 1'b0, 2'd1, 32'h0, 3, rd);  check("second_write", rd, 32'h77);

    // Read wins when both strobes are high
    access(1'b0, 1'b1, 2'd1, 32'hAA, 0, rd);
    access(1'b1, 1'b1, 2'd1, 32'h55, 0, rd); check("both_strobes_read", rd, 32'hAA);
    access(1'b1, 1'b0, 2'd1, 32'h0, 0, rd);  check("both_strobes_noload", rd, 32'hAA);

    // Reset during the wait phase of a write aborts it
    io_addr = 2'd1; io_write = 1'b1; tb_val = 32'h10;
    tick(1'b0, '0, '0);
    rst = 1'b1; io_write = 1'b0;
    tick(1'b0, '0, '0);
    rst = 1'b0;
    idle(1);
    access(1'b1, 1'b0, 2'd1, 32'h0, 0, rd);  check("abort_load", rd, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      a  = AW'($urandom);
      d  = $urandom;
      if (a == 2'd1 && $urandom_range(0, 4) != 0) d = DW'($urandom_range(0, 9));
      if (a == 2'd0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
      if (op < 5)       access(1'b1, 1'b0, a, d, $urandom_range(0, 3), rd);
      else if (op < 9)  access(1'b0, 1'b1, a, d, $urandom_range(0, 3), rd);
      else              access(1'b1, 1'b1, a, d, $urandom_range(0, 3), rd);
      idle($urandom_range(0, 3));
    end

    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
